// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module      : dmem_arbiter
// Description : Round-robin arbiter sharing a single-port data memory between
//               the core memory stage (port 0) and a debug/loader (port 1).
//               Optional address bounds check: define DMEM_ARB_BOUNDS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int MEM_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_error,

    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_error,

    output logic              mem_write_en,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_error
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;

    logic              r_last_grant;
    logic              r_port;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_error;

    logic              w_any_req;
    logic              w_grant_port;
    logic              w_accept;
    logic              w_oob;
    logic              w_in_access;
    logic              w_in_resp;

    // Contention goes to the port that did not win last time.
    always_comb begin
        w_any_req    = req0_valid | req1_valid;
        w_grant_port = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
        w_accept     = (r_state == S_IDLE) && w_any_req;
        w_in_access  = (r_state == S_ACCESS);
        w_in_resp    = (r_state == S_RESP);
    end

`ifdef DMEM_ARB_BOUNDS_EN
    localparam logic [ADDR_W-1:0] c_mem_words = ADDR_W'(MEM_WORDS);
    assign w_oob = (r_addr >= c_mem_words);
`else
    assign w_oob = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   w_state_next = w_accept ? S_ACCESS : S_IDLE;
            S_ACCESS: w_state_next = S_RESP;
            S_RESP:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch and response capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_port       <= 1'b0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rsp_rdata  <= '0;
            r_rsp_error  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_last_grant <= w_grant_port;
                r_port       <= w_grant_port;
                r_write      <= w_grant_port ? req1_write : req0_write;
                r_addr       <= w_grant_port ? req1_addr  : req0_addr;
                r_wdata      <= w_grant_port ? req1_wdata : req0_wdata;
            end
            if (w_in_access) begin
                // Read data is only meaningful for a clean, in-range read.
                r_rsp_rdata <= (!r_write && !w_oob && !mem_error) ? mem_rdata : '0;
                r_rsp_error <= w_oob | mem_error;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        mem_write_en = 1'b0;
        mem_read_en  = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        rsp0_valid   = 1'b0;
        rsp0_rdata   = '0;
        rsp0_error   = 1'b0;
        rsp1_valid   = 1'b0;
        rsp1_rdata   = '0;
        rsp1_error   = 1'b0;

        // Ready is gated by rst_n so the accept strobe drops the moment reset asserts.
        if (rst_n && w_accept) begin
            req0_ready = ~w_grant_port;
            req1_ready =  w_grant_port;
        end

        if (w_in_access) begin
            mem_addr     = r_addr;
            mem_wdata    = r_wdata;
            mem_write_en =  r_write && !w_oob;
            mem_read_en  = !r_write && !w_oob;
        end

        if (w_in_resp) begin
            if (r_port) begin
                rsp1_valid = 1'b1;
                rsp1_rdata = r_rsp_rdata;
                rsp1_error = r_rsp_error;
            end else begin
                rsp0_valid = 1'b1;
                rsp0_rdata = r_rsp_rdata;
                rsp0_error = r_rsp_error;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter with a small memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_write, req0_ready, rsp0_valid, rsp0_error;
    logic [63:0] req0_addr, req0_wdata, rsp0_rdata;
    logic        req1_valid, req1_write, req1_ready, rsp1_valid, rsp1_error;
    logic [63:0] req1_addr, req1_wdata, rsp1_rdata;
    logic        mem_write_en, mem_read_en, mem_error;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;

    logic        mem_init;
    logic        inj_err;
    logic        in_rst;
    logic [63:0] mem [0:15];

    int n_total = 0;
    int n_pass  = 0;
    int viol    = 0;
    int rst_bad = 0;

    dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_WORDS(1024)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
        .rsp0_rdata(rsp0_rdata), .rsp0_error(rsp0_error),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
        .rsp1_rdata(rsp1_rdata), .rsp1_error(rsp1_error),
        .mem_write_en(mem_write_en), .mem_read_en(mem_read_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_error(mem_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: 16 words, address aliased on the low 4 bits.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 64'h100 + 64'(i);
        end else if (mem_write_en) begin
            mem[mem_addr[3:0]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem_read_en ? mem[mem_addr[3:0]] : 64'h0;
    assign mem_error = (mem_write_en & mem_read_en) | inj_err;

    always @(negedge clk) begin
        if (mem_write_en && mem_read_en) viol++;
        if (rsp0_valid && rsp1_valid)    viol++;
        if (mem_error && !inj_err)       viol++;
        if (in_rst && (rsp0_valid || rsp1_valid || mem_write_en)) rst_bad++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic do_txn(input logic port, input logic wr, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic inj,
                          input logic [63:0] exp_rdata, input logic exp_err,
                          input string tag);
        logic oob;
        int   waits;
`ifdef DMEM_ARB_BOUNDS_EN
        oob = (addr >= 64'd1024);
`else
        oob = 1'b0;
`endif
        @(negedge clk);
        inj_err = inj;
        if (port) begin
            req1_valid = 1'b1; req1_write = wr; req1_addr = addr; req1_wdata = wdata;
        end else begin
            req0_valid = 1'b1; req0_write = wr; req0_addr = addr; req0_wdata = wdata;
        end
        #1;
        waits = 0;
        while (!(port ? req1_ready : req0_ready) && waits < 8) begin
            @(negedge clk); #1; waits++;
        end
        chk({tag, "_ready"},       64'(port ? req1_ready : req0_ready), 64'd1);
        chk({tag, "_other_ready"}, 64'(port ? req0_ready : req1_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk({tag, "_we"}, 64'(mem_write_en), 64'(wr && !oob));
        chk({tag, "_re"}, 64'(mem_read_en),  64'(!wr && !oob));
        if (!oob) chk({tag, "_maddr"}, mem_addr, addr);
        if (wr && !oob) chk({tag, "_mwdata"}, mem_wdata, wdata);
        @(negedge clk);
        #1;
        chk({tag, "_rspv"},       64'(port ? rsp1_valid : rsp0_valid), 64'd1);
        chk({tag, "_other_rspv"}, 64'(port ? rsp0_valid : rsp1_valid), 64'd0);
        chk({tag, "_rdata"}, port ? rsp1_rdata : rsp0_rdata, exp_rdata);
        chk({tag, "_err"},   64'(port ? rsp1_error : rsp0_error), 64'(exp_err));
        inj_err = 1'b0;
    endtask

    typedef struct {
        logic        port;
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        inj;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 64'd1,    64'h9876543210ABCDEF, 1'b0, 64'h0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 64'd1,    64'h0,                1'b0, 64'h9876543210ABCDEF, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 64'd2,    64'hAAAA5555AAAA5555, 1'b0, 64'h0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 64'd2,    64'h0,                1'b0, 64'hAAAA5555AAAA5555, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 64'd5,    64'h0,                1'b0, 64'h105, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 64'd1,    64'h0,                1'b0, 64'h9876543210ABCDEF, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 64'd3,    64'h1234,             1'b1, 64'h0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 64'd3,    64'h0,                1'b0, 64'h1234, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 64'd3,    64'h0,                1'b1, 64'h0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 64'd1023, 64'h0,                1'b0, 64'h10F, 1'b0};
`ifdef DMEM_ARB_BOUNDS_EN
        vecs[10] = '{1'b0, 1'b1, 64'd1024, 64'h55,               1'b0, 64'h0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 64'd1024, 64'h0,                1'b0, 64'h0, 1'b1};
`else
        vecs[10] = '{1'b0, 1'b1, 64'd1024, 64'h55,               1'b0, 64'h0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 64'd1024, 64'h0,                1'b0, 64'h55, 1'b0};
`endif

        rst_n = 1'b0; mem_init = 1'b1; inj_err = 1'b0; in_rst = 1'b0;
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 64'd1; req0_wdata = 64'h0;
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 64'd2; req1_wdata = 64'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_init = 1'b0;
        #1;
        chk("rst_ready0", 64'(req0_ready),   64'd0);
        chk("rst_ready1", 64'(req1_ready),   64'd0);
        chk("rst_rspv0",  64'(rsp0_valid),   64'd0);
        chk("rst_rspv1",  64'(rsp1_valid),   64'd0);
        chk("rst_we",     64'(mem_write_en), 64'd0);
        chk("rst_re",     64'(mem_read_en),  64'd0);
        chk("rst_maddr",  mem_addr,          64'd0);

        // Contention from reset: grants alternate 0,1,0,1, one accept every 3 cycles.
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk($sformatf("cont%0d_ready0", k), 64'(req0_ready), 64'(k % 2 == 0));
            chk($sformatf("cont%0d_ready1", k), 64'(req1_ready), 64'(k % 2 == 1));
            @(posedge clk);
            @(negedge clk);
            #1;
            chk($sformatf("cont%0d_acc_ready", k), 64'({req0_ready, req1_ready}), 64'd0);
            chk($sformatf("cont%0d_re", k), 64'(mem_read_en), 64'd1);
            @(negedge clk);
            #1;
            chk($sformatf("cont%0d_rspv0", k), 64'(rsp0_valid), 64'(k % 2 == 0));
            chk($sformatf("cont%0d_rspv1", k), 64'(rsp1_valid), 64'(k % 2 == 1));
            chk($sformatf("cont%0d_resp_ready", k), 64'({req0_ready, req1_ready}), 64'd0);
            chk($sformatf("cont%0d_rdata", k), (k % 2 == 0) ? rsp0_rdata : rsp1_rdata,
                (k % 2 == 0) ? 64'h101 : 64'h102);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Reset during ACCESS of a write to addr 5: write dropped, no response.
        @(negedge clk);
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 64'd5; req0_wdata = 64'hDEAD;
        #1 chk("rmid_ready0", 64'(req0_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 64'd2;
        #1 chk("rmid_we_pre", 64'(mem_write_en), 64'd1);
        rst_n = 1'b0; in_rst = 1'b1;
        #1;
        chk("rmid_we",     64'(mem_write_en), 64'd0);
        chk("rmid_maddr",  mem_addr,          64'd0);
        chk("rmid_ready1", 64'(req1_ready),   64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rmid_mem5",  mem[5], 64'h105);
        rst_n = 1'b1;
        #1 chk("rmid_release_ready1", 64'(req1_ready), 64'd1);
        req1_valid = 1'b0;
        repeat (3) @(negedge clk);
        in_rst = 1'b0;
        chk("rmid_no_rsp", 64'(rst_bad), 64'd0);

        for (int i = 0; i < NVEC; i++) begin
            do_txn(vecs[i].port, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].inj,
                   vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));
        end

        // Mixed random traffic against the memory model.
        for (int i = 0; i < 24; i++) begin
            logic        p, w;
            logic [63:0] a, d, e;
            p = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            a = 64'($urandom_range(0, 9));
            d = {$urandom, $urandom};
            e = w ? 64'h0 : mem[a[3:0]];
            do_txn(p, w, a, d, 1'b0, e, 1'b0, $sformatf("rnd%0d", i));
        end

        chk("mutex_violations", 64'(viol), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
